filter_sequencer: RTL and testbench

Per-sample scheduler for the channel strip's shared biquad engine. On each 48 kHz sample strobe it passes the sample through NUM_STAGES filter stages (lowpass, highpass, EQ bands) in order on one time-multiplexed engine, using a start/done handshake and selecting each stage's coefficient/state bank. Per-stage bypass is supported, along with a sticky overrun flag and an optional watchdog. It sits between the codec input and the output gain/mixer.

---
 rtl/filter_seq_pkg.sv | 22 ++
 rtl/seq_watchdog.sv | 32 +++
 rtl/filter_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_filter_sequencer.sv | 470 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/filter_seq_pkg.sv
// Shared types and defaults for the biquad-engine stage sequencer.
package filter_seq_pkg;

    localparam int DEF_NUM_STAGES = 4;
    localparam int DEF_DATA_W     = 16;
    localparam int DEF_TIMEOUT    = 64;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_EMIT  = 2'd3
    } seq_state_t;

    // Stage index width, never narrower than one bit.
    function automatic int idx_w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// WAIT-phase timeout: down-counter preloaded while clear is high, expires at terminal count.
module seq_watchdog
    import filter_seq_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int              CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= LOAD;
        end else if (clear) begin
            count <= LOAD;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    // The TIMEOUT-th enabled cycle sees the counter at zero.
    assign expired = enable && (count == '0);

endmodule

// File: rtl/filter_sequencer.sv
// Per-sample scheduler for the shared biquad engine: walks NUM_STAGES stages with bypass.
// Optional WAIT watchdog enabled by defining FILTER_SEQ_WATCHDOG_EN.
//
// state   | meaning
// IDLE    | waiting for sample_valid
// ISSUE   | current stage: skip if bypassed, otherwise start engine
// WAIT    | waiting for eng_done of current stage
// EMIT    | sample_out_valid pulse, then back to IDLE
module filter_sequencer
    import filter_seq_pkg::*;
#(
    parameter int   NUM_STAGES = DEF_NUM_STAGES,
    parameter int   DATA_W     = DEF_DATA_W,
    parameter int   TIMEOUT    = DEF_TIMEOUT,
    localparam int  IDX_W      = idx_w(NUM_STAGES)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sample_valid,
    input  logic signed [DATA_W-1:0] sample_in,
    input  logic [NUM_STAGES-1:0]    stage_bypass,
    input  logic                     flags_clr,
    output logic                     eng_start,
    output logic [IDX_W-1:0]         eng_sel,
    output logic signed [DATA_W-1:0] eng_in,
    input  logic signed [DATA_W-1:0] eng_out,
    input  logic                     eng_done,
    output logic signed [DATA_W-1:0] sample_out,
    output logic                     sample_out_valid,
    output logic                     busy,
    output logic                     overrun,
    output logic                     fault
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

    seq_state_t              state, state_nxt;
    logic [IDX_W-1:0]        idx, idx_nxt;
    logic [DATA_W-1:0]       work, work_nxt;
    logic [NUM_STAGES-1:0]   byp, byp_nxt;

    logic                    is_last;
    logic                    wd_expired;
    logic                    abort;
    logic                    drop;

    logic                    start_nxt;
    logic [IDX_W-1:0]        sel_nxt;
    logic [DATA_W-1:0]       in_nxt;
    logic [DATA_W-1:0]       out_nxt;
    logic                    out_valid_nxt;
    logic                    overrun_nxt;

    assign is_last = (idx == LAST_IDX);
    assign drop    = sample_valid && (state != S_IDLE);
    // eng_done on the expiry cycle still counts as a normal completion.
    assign abort   = (state == S_WAIT) && !eng_done && wd_expired;
    assign busy    = (state != S_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            idx   <= '0;
            work  <= '0;
            byp   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            work  <= work_nxt;
            byp   <= byp_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        work_nxt  = work;
        byp_nxt   = byp;
        unique case (state)
            S_IDLE: begin
                if (sample_valid) begin
                    work_nxt  = sample_in;
                    byp_nxt   = stage_bypass;
                    idx_nxt   = '0;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (byp[idx]) begin
                    if (is_last) begin
                        state_nxt = S_EMIT;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end else begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (eng_done) begin
                    work_nxt = eng_out;
                    if (is_last) begin
                        state_nxt = S_EMIT;
                    end else begin
                        idx_nxt   = idx + 1'b1;
                        state_nxt = S_ISSUE;
                    end
                end else if (abort) begin
                    state_nxt = S_IDLE;
                end
            end
            S_EMIT: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from next-state values so they are valid in the ISSUE/EMIT cycle itself.
    always_comb begin
        start_nxt     = 1'b0;
        sel_nxt       = eng_sel;
        in_nxt        = eng_in;
        out_valid_nxt = 1'b0;
        out_nxt       = sample_out;
        if ((state_nxt == S_ISSUE) && !byp_nxt[idx_nxt]) begin
            start_nxt = 1'b1;
            sel_nxt   = idx_nxt;
            in_nxt    = work_nxt;
        end
        if (state_nxt == S_EMIT) begin
            out_valid_nxt = 1'b1;
            out_nxt       = work_nxt;
        end
        if (drop) begin
            overrun_nxt = 1'b1;
        end else if (flags_clr) begin
            overrun_nxt = 1'b0;
        end else begin
            overrun_nxt = overrun;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            eng_start        <= 1'b0;
            eng_sel          <= '0;
            eng_in           <= '0;
            sample_out       <= '0;
            sample_out_valid <= 1'b0;
            overrun          <= 1'b0;
        end else begin
            eng_start        <= start_nxt;
            eng_sel          <= sel_nxt;
            eng_in           <= in_nxt;
            sample_out       <= out_nxt;
            sample_out_valid <= out_valid_nxt;
            overrun          <= overrun_nxt;
        end
    end

`ifdef FILTER_SEQ_WATCHDOG_EN
    seq_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (state != S_WAIT),
        .enable  (state == S_WAIT),
        .expired (wd_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault <= 1'b0;
        end else if (abort) begin
            fault <= 1'b1;
        end else if (flags_clr) begin
            fault <= 1'b0;
        end
    end
`else
    assign wd_expired = 1'b0;
    assign fault      = 1'b0;
`endif

endmodule

// File: tb/tb_filter_sequencer.sv
// Self-checking bench for filter_sequencer with a latency-programmable engine model.
module tb_filter_sequencer;

    localparam int NS = 4;
    localparam int DW = 16;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 sample_valid;
    logic signed [DW-1:0] sample_in;
    logic [NS-1:0]        stage_bypass;
    logic                 flags_clr;
    logic                 eng_start;
    logic [1:0]           eng_sel;
    logic signed [DW-1:0] eng_in;
    logic signed [DW-1:0] eng_out = '0;
    logic                 eng_done;
    logic signed [DW-1:0] sample_out;
    logic                 sample_out_valid;
    logic                 busy;
    logic                 overrun;
    logic                 fault;

    logic done_mdl = 1'b0;
    logic done_inj = 1'b0;
    assign eng_done = done_mdl | done_inj;

    int          tests = 0;
    int          fails = 0;
    int unsigned cyc = 0;
    int unsigned t0 = 0;

    logic [DW-1:0] off [NS];
    int            lat_stage [NS];
    bit            eng_on = 1'b1;
    bit            pend = 1'b0;
    int            cnt = 0;
    int            psel = 0;
    logic [DW-1:0] pin = '0;
    int            starts = 0;

    int            sel_q[$];
    int unsigned   out_cyc_q[$];
    logic [DW-1:0] out_val_q[$];

    filter_sequencer dut (
        .clk              (clk),
        .reset            (reset),
        .sample_valid     (sample_valid),
        .sample_in        (sample_in),
        .stage_bypass     (stage_bypass),
        .flags_clr        (flags_clr),
        .eng_start        (eng_start),
        .eng_sel          (eng_sel),
        .eng_in           (eng_in),
        .eng_out          (eng_out),
        .eng_done         (eng_done),
        .sample_out       (sample_out),
        .sample_out_valid (sample_out_valid),
        .busy             (busy),
        .overrun          (overrun),
        .fault            (fault)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Engine: start seen in cycle c, done pulsed during cycle c + lat_stage[sel]; result = in + off[sel].
    always @(negedge clk) begin
        done_mdl = 1'b0;
        if (pend) begin
            cnt = cnt - 1;
            if (cnt == 0) begin
                pend     = 1'b0;
                done_mdl = 1'b1;
                eng_out  = pin + off[psel];
            end
        end
        if (eng_start === 1'b1) begin
            starts = starts + 1;
            sel_q.push_back(int'(eng_sel));
            if (eng_on) begin
                pend = 1'b1;
                psel = int'(eng_sel);
                cnt  = lat_stage[psel];
                pin  = eng_in;
            end
        end
    end

    always @(negedge clk) begin
        if (sample_out_valid === 1'b1) begin
            out_cyc_q.push_back(cyc);
            out_val_q.push_back(sample_out);
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "timeout");
    end

    task automatic clear_logs();
        sel_q.delete();
        out_cyc_q.delete();
        out_val_q.delete();
        starts = 0;
    endtask

    task automatic set_engine(input logic [DW-1:0] o, input int l);
        for (int i = 0; i < NS; i++) begin
            off[i]       = o;
            lat_stage[i] = l;
        end
    endtask

    task automatic start_sample(input logic [DW-1:0] din, input logic [NS-1:0] byp);
        @(negedge clk);
        sample_in    = din;
        stage_bypass = byp;
        sample_valid = 1'b1;
        t0           = cyc;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic wait_out(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(posedge clk);
            if (out_val_q.size() > 0) got = 1'b1;
        end
    endtask

    task automatic wait_cycle(input int unsigned target);
        while (cyc < target) @(negedge clk);
    endtask

    function automatic void model(input logic [DW-1:0] din, input logic [NS-1:0] byp,
                                  output logic [DW-1:0] val, output int unsigned lat);
        val = din;
        lat = 1;
        for (int i = 0; i < NS; i++) begin
            if (byp[i]) begin
                lat = lat + 1;
            end else begin
                val = val + off[i];
                lat = lat + 1 + lat_stage[i];
            end
        end
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if ({eng_start, eng_sel, eng_in, sample_out, sample_out_valid, busy, overrun, fault} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got start=%b sel=%0d in=%h out=%h v=%b busy=%b ovr=%b flt=%b, required all 0",
                     eng_start, eng_sel, eng_in, sample_out, sample_out_valid, busy, overrun, fault);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_all_bypass();
        bit got;
        clear_logs();
        set_engine(16'h0001, 2);
        start_sample(16'h4000, 4'b1111);
        wait_out(40, got);
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL all_bypass_timeout: no sample_out_valid within 40 cycles");
        end else begin
            tests++;
            if (out_cyc_q[0] - t0 !== 5) begin
                fails++;
                $display("FAIL all_bypass_latency: got %0d required 5", out_cyc_q[0] - t0);
            end
            tests++;
            if (out_val_q[0] !== 16'h4000) begin
                fails++;
                $display("FAIL all_bypass_value: got %h required 4000", out_val_q[0]);
            end
        end
        tests++;
        if (starts !== 0) begin
            fails++;
            $display("FAIL all_bypass_starts: got %0d required 0", starts);
        end
    endtask

    task automatic test_no_bypass();
        bit got;
        clear_logs();
        set_engine(16'h0001, 2);
        start_sample(16'h4000, 4'b0000);
        wait_out(60, got);
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL no_bypass_timeout: no sample_out_valid within 60 cycles");
        end else begin
            tests++;
            if (out_cyc_q[0] - t0 !== 13) begin
                fails++;
                $display("FAIL no_bypass_latency: got %0d required 13", out_cyc_q[0] - t0);
            end
            tests++;
            if (out_val_q[0] !== 16'h4004) begin
                fails++;
                $display("FAIL no_bypass_value: got %h required 4004", out_val_q[0]);
            end
        end
        tests++;
        if (sel_q.size() != 4 || sel_q[0] != 0 || sel_q[1] != 1 || sel_q[2] != 2 || sel_q[3] != 3) begin
            fails++;
            $display("FAIL no_bypass_sel_seq: got %p required 0,1,2,3", sel_q);
        end
    endtask

    task automatic test_bypass_0101();
        bit got;
        clear_logs();
        set_engine(16'h0001, 2);
        start_sample(16'h1234, 4'b0101);
        wait_out(60, got);
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL bypass_0101_timeout: no sample_out_valid within 60 cycles");
        end else begin
            tests++;
            if (out_val_q[0] !== 16'h1236) begin
                fails++;
                $display("FAIL bypass_0101_value: got %h required 1236", out_val_q[0]);
            end
            tests++;
            if (out_cyc_q[0] - t0 !== 9) begin
                fails++;
                $display("FAIL bypass_0101_latency: got %0d required 9", out_cyc_q[0] - t0);
            end
        end
        tests++;
        if (sel_q.size() != 2 || sel_q[0] != 1 || sel_q[1] != 3) begin
            fails++;
            $display("FAIL bypass_0101_sel_seq: got %p required 1,3", sel_q);
        end
    endtask

    task automatic test_random();
        bit            got;
        logic [DW-1:0] din, exp_val;
        logic [NS-1:0] byp;
        int unsigned   exp_lat;
        int            k;
        bit            seq_ok;
        for (int n = 0; n < 25; n++) begin
            clear_logs();
            for (int i = 0; i < NS; i++) begin
                off[i]       = DW'($urandom);
                lat_stage[i] = int'($urandom_range(1, 4));
            end
            din = DW'($urandom);
            byp = NS'($urandom);
            model(din, byp, exp_val, exp_lat);
            start_sample(din, byp);
            wait_out(exp_lat + 20, got);
            tests++;
            if (!got) begin
                fails++;
                $display("FAIL random_timeout[%0d]: no output, expected latency %0d", n, exp_lat);
                continue;
            end
            tests++;
            if (out_val_q[0] !== exp_val || out_cyc_q[0] - t0 !== exp_lat) begin
                fails++;
                $display("FAIL random_result[%0d]: got %h @%0d required %h @%0d (in=%h byp=%b)",
                         n, out_val_q[0], out_cyc_q[0] - t0, exp_val, exp_lat, din, byp);
            end
            k = 0;
            seq_ok = 1'b1;
            for (int i = 0; i < NS; i++) begin
                if (!byp[i]) begin
                    if (k >= sel_q.size() || sel_q[k] != i) seq_ok = 1'b0;
                    k++;
                end
            end
            tests++;
            if (!seq_ok || k != sel_q.size()) begin
                fails++;
                $display("FAIL random_sel_seq[%0d]: got %p for bypass %b", n, sel_q, byp);
            end
        end
    endtask

    task automatic test_overrun();
        bit got;
        clear_logs();
        set_engine(16'h0001, 3);
        start_sample(16'h0100, 4'b0000);
        wait_cycle(t0 + 3);
        sample_in    = 16'h7777;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        tests++;
        if (overrun !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL overrun_set: got overrun=%b busy=%b required 1 1", overrun, busy);
        end
        wait_out(60, got);
        repeat (20) @(negedge clk);
        tests++;
        if (!got || out_val_q.size() != 1) begin
            fails++;
            $display("FAIL overrun_outputs: got %0d outputs required 1", out_val_q.size());
        end else begin
            tests++;
            if (out_val_q[0] !== 16'h0104 || out_cyc_q[0] - t0 !== 17) begin
                fails++;
                $display("FAIL overrun_first_sample: got %h @%0d required 0104 @17",
                         out_val_q[0], out_cyc_q[0] - t0);
            end
        end
        clear_logs();
        start_sample(16'h0200, 4'b0000);
        flags_clr    = 1'b1;
        sample_valid = 1'b1;
        @(negedge clk);
        flags_clr    = 1'b0;
        sample_valid = 1'b0;
        tests++;
        if (overrun !== 1'b1) begin
            fails++;
            $display("FAIL overrun_set_wins: got %b required 1", overrun);
        end
        wait_out(60, got);
        @(negedge clk);
        flags_clr = 1'b1;
        @(negedge clk);
        flags_clr = 1'b0;
        tests++;
        if (overrun !== 1'b0) begin
            fails++;
            $display("FAIL overrun_clear: got %b required 0", overrun);
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        clear_logs();
        set_engine(16'h0001, 3);
        start_sample(16'h0AAA, 4'b0000);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (eng_sel == 2'd2 && eng_start === 1'b0 && busy === 1'b1) found = 1'b1;
            else @(negedge clk);
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL reset_mid_reach_wait2: stage 2 WAIT not reached");
        end
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if ({eng_start, eng_sel, eng_in, sample_out, sample_out_valid, busy, overrun, fault} !== '0) begin
            fails++;
            $display("FAIL reset_mid_outputs: got start=%b sel=%0d in=%h out=%h v=%b busy=%b, required all 0",
                     eng_start, eng_sel, eng_in, sample_out, sample_out_valid, busy);
        end
        reset = 1'b0;
        repeat (10) @(negedge clk);
        tests++;
        if (out_val_q.size() != 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_stale_done: got %0d outputs busy=%b required 0 0", out_val_q.size(), busy);
        end
    endtask

    task automatic test_watchdog();
        bit got;
`ifdef FILTER_SEQ_WATCHDOG_EN
        clear_logs();
        set_engine(16'h0001, 1);
        eng_on = 1'b0;
        start_sample(16'h0100, 4'b0000);
        wait_cycle(t0 + 65);
        tests++;
        if (busy !== 1'b1 || fault !== 1'b0) begin
            fails++;
            $display("FAIL watchdog_before_expiry: got busy=%b fault=%b required 1 0", busy, fault);
        end
        @(negedge clk);
        tests++;
        if (fault !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL watchdog_abort: got fault=%b busy=%b required 1 0", fault, busy);
        end
        done_inj = 1'b1;
        @(negedge clk);
        done_inj = 1'b0;
        repeat (5) @(negedge clk);
        tests++;
        if (out_val_q.size() != 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL watchdog_late_done: got %0d outputs busy=%b required 0 0", out_val_q.size(), busy);
        end
        eng_on = 1'b1;
        clear_logs();
        start_sample(16'h0100, 4'b0000);
        wait_out(40, got);
        tests++;
        if (!got || out_val_q[0] !== 16'h0104 || out_cyc_q[0] - t0 !== 9) begin
            fails++;
            $display("FAIL watchdog_next_sample: got valid=%b required 0104 @9", got);
        end
        @(negedge clk);
        flags_clr = 1'b1;
        @(negedge clk);
        flags_clr = 1'b0;
        tests++;
        if (fault !== 1'b0) begin
            fails++;
            $display("FAIL watchdog_fault_clear: got %b required 0", fault);
        end
`else
        clear_logs();
        set_engine(16'h0003, 1);
        lat_stage[0] = 100;
        start_sample(16'h0010, 4'b1110);
        wait_out(150, got);
        tests++;
        if (!got || out_val_q[0] !== 16'h0013 || out_cyc_q[0] - t0 !== 105) begin
            fails++;
            $display("FAIL long_wait_no_watchdog: got valid=%b required 0013 @105", got);
        end
        tests++;
        if (fault !== 1'b0) begin
            fails++;
            $display("FAIL fault_tied_low: got %b required 0", fault);
        end
`endif
    endtask

    initial begin
        reset        = 1'b1;
        sample_valid = 1'b0;
        sample_in    = '0;
        stage_bypass = '0;
        flags_clr    = 1'b0;
        set_engine(16'h0001, 2);
        test_reset();
        test_all_bypass();
        test_no_bypass();
        test_bypass_0101();
        test_random();
        test_overrun();
        test_reset_mid();
        test_watchdog();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
